pipeline_stall_controller: RTL and testbench

Sequences the s0 operand-select stage: generates the `clk_enable` that gates operand capture, and injects bubbles into s1.
- Tracks in-flight destination registers in a shift-register scoreboard and stalls s0 on read-after-write hazards.
- Freezes the whole pipeline while the memory stage is busy.
- Squashes on branch flush.
- Sits between instruction decode and the pre-ALU operand registers.

---
 rtl/pipeline_stall_controller_if.sv | 33 +++
 rtl/pipeline_stall_controller.sv | 162 ++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_if.sv
// Issue/hazard handshake bundle between decode and s0 control.
// master drives the instruction side, slave is the stall controller.
interface pipeline_stall_controller_if;
  logic        issue_valid;
  logic [4:0]  rs1;
  logic        rs1_used;
  logic [4:0]  rs2;
  logic        rs2_used;
  logic [4:0]  rd;
  logic        rd_write;
  logic        is_load;
  logic        mem_busy;
  logic        flush;
  logic        stage_enable;
  logic        bubble;
  logic [1:0]  state;
  logic [15:0] stall_count;
  logic        mem_timeout;

  modport master (
    output issue_valid, rs1, rs1_used, rs2, rs2_used,
    output rd, rd_write, is_load, mem_busy, flush,
    input  stage_enable, bubble, state, stall_count,
    input  mem_timeout
  );

  modport slave (
    input  issue_valid, rs1, rs1_used, rs2, rs2_used,
    input  rd, rd_write, is_load, mem_busy, flush,
    output stage_enable, bubble, state, stall_count,
    output mem_timeout
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// s0 stall/freeze/flush sequencer with shift-register RAW scoreboard.
// FORWARD_EN: when defined, only load-use on entry 0 stalls.
module pipeline_stall_controller #(
  parameter int WB_DEPTH    = 3,
  parameter int MEM_TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  pipeline_stall_controller_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2,
    FLUSH  = 2'd3
  } mode_e;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } sb_t;

  localparam logic [15:0] TO = 16'(MEM_TIMEOUT);

  sb_t         sb [WB_DEPTH];
  sb_t         push;
  mode_e       state_q;
  mode_e       mode;
  logic        pend_q;
  logic [15:0] stall_q;
  logic [15:0] busy_q;
  logic [15:0] busy_inc;
  logic        to_q;
  logic        hazard;
  logic        frz;
  logic        fls;
  logic        stl;

  function automatic logic hit(
    sb_t e, logic [4:0] r, logic u
  );
    return u & (r != 5'd0) & e.v & (e.rd == r);
  endfunction

  // RAW hazard against in-flight destinations
  always_comb begin
    hazard = 1'b0;
`ifdef FORWARD_EN
    hazard = sb[0].ld &
      (hit(sb[0], bus.rs1, bus.rs1_used) |
       hit(sb[0], bus.rs2, bus.rs2_used));
`else
    for (int i = 0; i < WB_DEPTH; i++)
      hazard = hazard |
        hit(sb[i], bus.rs1, bus.rs1_used) |
        hit(sb[i], bus.rs2, bus.rs2_used);
`endif
    hazard = hazard & bus.issue_valid;
  end

  // next-state: freeze > flush > stall > run
  always_comb begin
    frz  = bus.mem_busy;
    fls  = ~frz & (bus.flush | pend_q);
    stl  = ~frz & ~fls & hazard;
    mode = RUN;
    unique case (1'b1)
      frz:     mode = FREEZE;
      fls:     mode = FLUSH;
      stl:     mode = STALL;
      default: mode = RUN;
    endcase
  end

  // stage controls and scoreboard push value
  always_comb begin
    bus.stage_enable = 1'b0;
    bus.bubble       = 1'b1;
    push             = '0;
    if (rst_n) begin
      unique case (mode)
        RUN: begin
          bus.stage_enable = 1'b1;
          bus.bubble       = 1'b0;
          push.v  = bus.issue_valid & bus.rd_write &
                    (bus.rd != 5'd0);
          push.rd = bus.rd;
          push.ld = bus.is_load;
        end
        STALL: begin
          bus.stage_enable = 1'b0;
          bus.bubble       = 1'b1;
        end
        FREEZE: begin
          bus.stage_enable = 1'b0;
          bus.bubble       = 1'b0;
        end
        FLUSH: begin
          bus.stage_enable = 1'b1;
          bus.bubble       = 1'b1;
        end
      endcase
    end
  end

  assign busy_inc = (busy_q == 16'hFFFF) ?
                    busy_q : busy_q + 16'd1;

  // state register follows the chosen mode
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= mode;
  end

  // scoreboard shift; held while frozen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WB_DEPTH; i++)
        sb[i] <= '0;
    end else if (mode != FREEZE) begin
      sb[0] <= push;
      for (int i = 1; i < WB_DEPTH; i++)
        sb[i] <= (i == 1 && mode == FLUSH) ?
                 '0 : sb[i-1];
    end
  end

  // saturating hazard stall counter
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_q <= '0;
    else if (mode == STALL && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  // consecutive busy counter and sticky timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      to_q   <= 1'b0;
    end else if (bus.mem_busy) begin
      busy_q <= busy_inc;
      if (busy_inc >= TO) to_q <= 1'b1;
    end else begin
      busy_q <= '0;
    end
  end

  // remember a flush that arrived during a freeze
  always_ff @(posedge clk) begin
    if (!rst_n)            pend_q <= 1'b0;
    else if (bus.mem_busy) pend_q <= pend_q | bus.flush;
    else                   pend_q <= 1'b0;
  end

  assign bus.state       = state_q;
  assign bus.stall_count = stall_q;
  assign bus.mem_timeout = to_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller.
// Expected outputs queued per step, popped at negedge.
module tb_pipeline_stall_controller;

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_STALL  = 2'd1;
  localparam logic [1:0] S_FREEZE = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  typedef struct {
    logic        en;
    logic        bub;
    logic [1:0]  st;
    logic [15:0] sc;
    logic        to;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  logic [15:0] exp_sc;
  exp_t q[$];

  pipeline_stall_controller_if bus ();

  pipeline_stall_controller #(
    .WB_DEPTH    (3),
    .MEM_TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  function automatic exp_t mk(
    logic en, logic bub, logic [1:0] st,
    logic [15:0] sc, logic to
  );
    exp_t e;
    e.en = en; e.bub = bub; e.st = st;
    e.sc = sc; e.to = to;
    return e;
  endfunction

  task automatic cmp(
    string tag, logic [15:0] got, logic [15:0] exp
  );
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic drive(
    logic iv, logic [4:0] r1, logic u1,
    logic [4:0] r2, logic u2, logic [4:0] d,
    logic w, logic ld, logic mb, logic fl
  );
    bus.issue_valid = iv;
    bus.rs1 = r1; bus.rs1_used = u1;
    bus.rs2 = r2; bus.rs2_used = u2;
    bus.rd = d; bus.rd_write = w;
    bus.is_load = ld;
    bus.mem_busy = mb; bus.flush = fl;
  endtask

  task automatic step(string tag, exp_t e);
    exp_t x;
    q.push_back(e);
    @(negedge clk);
    if (q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: scoreboard queue empty", tag);
    end else begin
      x = q.pop_front();
      cmp({tag, ".en"},  16'(bus.stage_enable), 16'(x.en));
      cmp({tag, ".bub"}, 16'(bus.bubble), 16'(x.bub));
      cmp({tag, ".st"},  16'(bus.state), 16'(x.st));
      cmp({tag, ".sc"},  bus.stall_count, x.sc);
      cmp({tag, ".to"},  16'(bus.mem_timeout), 16'(x.to));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic stall_seq(
    string tag, logic [4:0] r, logic ld,
    logic use2, int n
  );
    drive(1, 0, 0, 0, 0, r, 1, ld, 0, 0);
    step({tag, "_prod"}, mk(1, 0, S_RUN, exp_sc, 0));
    drive(1, use2 ? 5'd0 : r, ~use2,
          use2 ? r : 5'd0, use2, 0, 0, 0, 0, 0);
    for (int k = 0; k < n; k++)
      step({tag, "_stall"},
           mk(0, 1, (k == 0) ? S_RUN : S_STALL,
              exp_sc + 16'(k), 0));
    step({tag, "_go"},
         mk(1, 0, (n > 0) ? S_STALL : S_RUN,
            exp_sc + 16'(n), 0));
    exp_sc = exp_sc + 16'(n);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    exp_sc = '0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    step("reset", mk(0, 1, S_RUN, 0, 0));
    rst_n = 1'b1;

    // dependent issue right after producer
`ifdef FORWARD_EN
    stall_seq("raw_alu", 5'd5, 1'b0, 1'b0, 0);
    stall_seq("raw_load", 5'd5, 1'b1, 1'b1, 1);
`else
    stall_seq("raw_alu", 5'd5, 1'b0, 1'b0, 3);
    stall_seq("raw_load", 5'd5, 1'b1, 1'b1, 3);
`endif

    // x0 never hazards
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("x0_wr", mk(1, 0, S_RUN, exp_sc, 0));
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    step("x0_rd", mk(1, 0, S_RUN, exp_sc, 0));

    // freeze with flush in cycle 2
    drive(1, 0, 0, 0, 0, 5'd7, 1, 0, 0, 0);
    step("frz_prod", mk(1, 0, S_RUN, exp_sc, 0));
    drive(1, 5'd7, 1, 0, 0, 0, 0, 0, 1, 0);
    step("frz1", mk(0, 0, S_RUN, exp_sc, 0));
    drive(1, 5'd7, 1, 0, 0, 0, 0, 0, 1, 1);
    step("frz2", mk(0, 0, S_FREEZE, exp_sc, 0));
    drive(1, 5'd7, 1, 0, 0, 0, 0, 0, 1, 0);
    step("frz3", mk(0, 0, S_FREEZE, exp_sc, 0));
    step("frz4", mk(0, 0, S_FREEZE, exp_sc, 0));
    drive(1, 5'd7, 1, 0, 0, 0, 0, 0, 0, 0);
    step("pend_fl", mk(1, 1, S_FREEZE, exp_sc, 0));
    step("post_fl", mk(1, 0, S_FLUSH, exp_sc, 0));

    // flush beats hazard, no stall counted
    drive(1, 0, 0, 0, 0, 5'd9, 1, 0, 0, 0);
    step("fh_prod", mk(1, 0, S_RUN, exp_sc, 0));
    drive(1, 5'd9, 1, 0, 0, 0, 0, 0, 0, 1);
    step("fh_flush", mk(1, 1, S_RUN, exp_sc, 0));
    drive(1, 5'd9, 1, 0, 0, 0, 0, 0, 0, 0);
    step("fh_after", mk(1, 0, S_FLUSH, exp_sc, 0));

    // timeout after 8 busy cycles, sticky
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 10; i++)
      step("tmo_busy",
           mk(0, 0, (i == 1) ? S_RUN : S_FREEZE,
              exp_sc, (i > 8) ? 1'b1 : 1'b0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("tmo_drop", mk(1, 0, S_FREEZE, exp_sc, 1));
    step("tmo_hold", mk(1, 0, S_RUN, exp_sc, 1));

    // reset in the middle of a stall
    drive(1, 0, 0, 0, 0, 5'd12, 1, 1, 0, 0);
    step("rs_prod", mk(1, 0, S_RUN, exp_sc, 1));
    drive(1, 5'd12, 1, 0, 0, 0, 0, 0, 0, 0);
    step("rs_stall", mk(0, 1, S_RUN, exp_sc, 1));
    rst_n = 1'b0;
    step("rs_reset",
         mk(0, 1, S_STALL, exp_sc + 16'd1, 1));
    rst_n = 1'b1;
    step("rs_reissue", mk(1, 0, S_RUN, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rs_idle", mk(1, 0, S_RUN, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
